// File: rtl/fifo_tb_pkg.sv
// Shared types for the grant pattern generator: mode/FSM enums, LFSR taps and helpers.
// The helpers are pure functions and add no registers.
package fifo_tb_pkg;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_RAND  = 2'd1,
        MODE_ON    = 2'd2,
        MODE_BURST = 2'd3
    } grant_mode_e;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        BURST_ON  = 2'd1,
        BURST_OFF = 2'd2
    } burst_state_e;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Galois form: shift right, fold the taps in when the bit shifted out is set.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
    endfunction

    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    function automatic logic [15:0] chan_seed(input logic [15:0] base, input int unsigned idx);
        logic [15:0] s;
        s = base ^ idx[15:0];
        return (s == 16'h0000) ? 16'h0001 : s;
    endfunction

endpackage

// File: rtl/fifo_grant_chan.sv
// One grant channel: config regs, free-running LFSR, burst FSM; grant is registered, one cycle after config load.
// FIFO_GRANT_STATS_EN adds a saturating count of granted cycles; channels never backpressure.
module fifo_grant_chan
    import fifo_tb_pkg::*;
#(
    parameter int          BW_W     = 8,
    parameter int          CNT_W    = 8,
    parameter logic [15:0] SEED_VAL = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid_i,
    input  grant_mode_e      mode_i,
    input  logic [BW_W:0]    bw_i,
    input  logic [CNT_W-1:0] on_len_i,
    input  logic [CNT_W-1:0] off_len_i,
    output logic             grant_o
`ifdef FIFO_GRANT_STATS_EN
    ,
    output logic [31:0]      grant_cnt_o
`endif
);

    grant_mode_e      mode_q,    mode_d;
    logic [BW_W:0]    bw_q,      bw_d;
    logic [CNT_W-1:0] on_len_q,  on_len_d;
    logic [CNT_W-1:0] off_len_q, off_len_d;
    burst_state_e     state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [15:0]      lfsr_q,    lfsr_d;
    logic             grant_q,   grant_d;

    always_comb begin
        mode_d    = mode_q;
        bw_d      = bw_q;
        on_len_d  = on_len_q;
        off_len_d = off_len_q;
        state_d   = state_q;
        cnt_d     = cnt_q;
        lfsr_d    = lfsr_next(lfsr_q);

        // Grant depends only on registered config so a load shows up one edge later.
        // BW_W is assumed to be at most 16 (the LFSR width).
        case (mode_q)
            MODE_ON:    grant_d = 1'b1;
            MODE_RAND:  grant_d = ({1'b0, lfsr_q[BW_W-1:0]} < bw_q);
            MODE_BURST: grant_d = (state_q == BURST_ON);
            default:    grant_d = 1'b0;
        endcase

        if (cfg_valid_i) begin
            mode_d    = mode_i;
            bw_d      = bw_i;
            on_len_d  = on_len_i;
            off_len_d = off_len_i;
            if (mode_i == MODE_BURST) begin
                if (on_len_i != '0) begin
                    state_d = BURST_ON;
                    cnt_d   = on_len_i;
                end else begin
                    state_d = BURST_OFF;
                    cnt_d   = off_len_i;
                end
            end else begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        end else begin
            case (state_q)
                BURST_ON: begin
                    // A zero OFF length parks the channel in BURST_ON.
                    if (cnt_q == CNT_W'(1) && off_len_q != '0) begin
                        state_d = BURST_OFF;
                        cnt_d   = off_len_q;
                    end else if (cnt_q > CNT_W'(1)) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                BURST_OFF: begin
                    if (cnt_q <= CNT_W'(1)) begin
                        if (on_len_q != '0) begin
                            state_d = BURST_ON;
                            cnt_d   = on_len_q;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q    <= MODE_OFF;
            bw_q      <= '0;
            on_len_q  <= '0;
            off_len_q <= '0;
            state_q   <= IDLE;
            cnt_q     <= '0;
            lfsr_q    <= SEED_VAL;
            grant_q   <= 1'b0;
        end else begin
            mode_q    <= mode_d;
            bw_q      <= bw_d;
            on_len_q  <= on_len_d;
            off_len_q <= off_len_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            lfsr_q    <= lfsr_d;
            grant_q   <= grant_d;
        end
    end

    assign grant_o = grant_q;

`ifdef FIFO_GRANT_STATS_EN
    logic [31:0] stat_q, stat_d;

    // Counts with grant_d so the value tracks the number of 1s already seen on grant_o.
    always_comb begin
        stat_d = stat_q;
        if (cfg_valid_i) begin
            stat_d = '0;
        end else if (grant_d && stat_q != 32'hFFFF_FFFF) begin
            stat_d = stat_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_q <= '0;
        end else begin
            stat_q <= stat_d;
        end
    end

    assign grant_cnt_o = stat_q;
`endif

endmodule

// File: rtl/fifo_grant_pattern_gen.sv
// NUM_CH independent grant channels driving fifo_if grant_in; grant_o registered, one cycle after config load.
// FIFO_GRANT_STATS_EN adds per-channel grant_cnt_o; no backpressure path.
module fifo_grant_pattern_gen
    import fifo_tb_pkg::*;
#(
    parameter int          NUM_CH = 1,
    parameter int          BW_W   = 8,
    parameter int          CNT_W  = 8,
    parameter logic [15:0] SEED   = 16'hACE1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cfg_valid_i,
    input  grant_mode_e [NUM_CH-1:0]     mode_i,
    input  logic [NUM_CH-1:0][BW_W:0]    bw_i,
    input  logic [NUM_CH-1:0][CNT_W-1:0] burst_on_i,
    input  logic [NUM_CH-1:0][CNT_W-1:0] burst_off_i,
    output logic [NUM_CH-1:0]            grant_o
`ifdef FIFO_GRANT_STATS_EN
    ,
    output logic [NUM_CH-1:0][31:0]      grant_cnt_o
`endif
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
        fifo_grant_chan #(
            .BW_W     (BW_W),
            .CNT_W    (CNT_W),
            .SEED_VAL (chan_seed(SEED, i))
        ) u_chan (
            .clk         (clk),
            .rst         (rst),
            .cfg_valid_i (cfg_valid_i),
            .mode_i      (mode_i[i]),
            .bw_i        (bw_i[i]),
            .on_len_i    (burst_on_i[i]),
            .off_len_i   (burst_off_i[i]),
            .grant_o     (grant_o[i])
`ifdef FIFO_GRANT_STATS_EN
            ,
            .grant_cnt_o (grant_cnt_o[i])
`endif
        );
    end

endmodule

// File: tb/tb_fifo_grant_pattern_gen.sv
// Directed bench for the two-channel grant pattern generator with hand-computed expectations.
module tb_fifo_grant_pattern_gen;
    import fifo_tb_pkg::*;

    localparam int NUM_CH = 2;
    localparam int BW_W   = 8;
    localparam int CNT_W  = 8;

    logic                          clk;
    logic                          rst;
    logic                          cfg_valid_i;
    grant_mode_e [NUM_CH-1:0]      mode_i;
    logic [NUM_CH-1:0][BW_W:0]     bw_i;
    logic [NUM_CH-1:0][CNT_W-1:0]  burst_on_i;
    logic [NUM_CH-1:0][CNT_W-1:0]  burst_off_i;
    logic [NUM_CH-1:0]             grant_o;
`ifdef FIFO_GRANT_STATS_EN
    logic [NUM_CH-1:0][31:0]       grant_cnt_o;
`endif

    int n_chk = 0;
    int n_err = 0;

    fifo_grant_pattern_gen #(
        .NUM_CH (NUM_CH),
        .BW_W   (BW_W),
        .CNT_W  (CNT_W),
        .SEED   (16'hACE1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_valid_i (cfg_valid_i),
        .mode_i      (mode_i),
        .bw_i        (bw_i),
        .burst_on_i  (burst_on_i),
        .burst_off_i (burst_off_i),
        .grant_o     (grant_o)
`ifdef FIFO_GRANT_STATS_EN
        ,
        .grant_cnt_o (grant_cnt_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation still running, required to finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, obs, exp);
        end
    endtask

    // Config is presented for exactly one rising edge; returns just after that edge.
    task automatic load(input grant_mode_e m0, input logic [BW_W:0] b0,
                        input logic [CNT_W-1:0] on0, input logic [CNT_W-1:0] off0,
                        input grant_mode_e m1, input logic [BW_W:0] b1,
                        input logic [CNT_W-1:0] on1, input logic [CNT_W-1:0] off1);
        @(negedge clk);
        cfg_valid_i    = 1'b1;
        mode_i[0]      = m0;
        bw_i[0]        = b0;
        burst_on_i[0]  = on0;
        burst_off_i[0] = off0;
        mode_i[1]      = m1;
        bw_i[1]        = b1;
        burst_on_i[1]  = on1;
        burst_off_i[1] = off1;
        @(negedge clk);
        cfg_valid_i    = 1'b0;
    endtask

    task automatic run_count(input int n, output int c0, output int c1);
        c0 = 0;
        c1 = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (grant_o[0] === 1'b1) c0++;
            if (grant_o[1] === 1'b1) c1++;
        end
    endtask

    initial begin
        int c0, c1;
        logic [4:0] burst_pat;
        logic [2:0] ind_pat;

        rst            = 1'b1;
        cfg_valid_i    = 1'b0;
        mode_i         = {MODE_OFF, MODE_OFF};
        bw_i           = '0;
        burst_on_i     = '0;
        burst_off_i    = '0;

        repeat (3) @(negedge clk);
        chk("rst_grant", 32'(grant_o), 32'h0);
        rst = 1'b0;

        run_count(100, c0, c1);
        chk("idle_ch0_cnt", c0, 0);
        chk("idle_ch1_cnt", c1, 0);

        // ch0 ON, ch1 OFF
        load(MODE_ON, 9'd0, 8'd0, 8'd0, MODE_OFF, 9'd0, 8'd0, 8'd0);
        @(negedge clk);
        chk("on_off_first", 32'(grant_o), 32'h1);
        run_count(20, c0, c1);
        chk("on_ch0_cnt", c0, 20);
        chk("off_ch1_cnt", c1, 0);

        // burst 3 on / 2 off: 1,1,1,0,0 repeating (bit i = cycle i)
        burst_pat = 5'b00111;
        load(MODE_BURST, 9'd0, 8'd3, 8'd2, MODE_OFF, 9'd0, 8'd0, 8'd0);
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            chk("burst_3_2", 32'(grant_o), {31'b0, burst_pat[i % 5]});
        end

        // reload mid-burst restarts at the ON phase
        repeat (2) @(negedge clk);
        load(MODE_BURST, 9'd0, 8'd3, 8'd2, MODE_OFF, 9'd0, 8'd0, 8'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("burst_restart", 32'(grant_o), {31'b0, burst_pat[i]});
        end

        // independence: ch0 burst 2/1 (1,1,0), ch1 ON
        ind_pat = 3'b011;
        load(MODE_BURST, 9'd0, 8'd2, 8'd1, MODE_ON, 9'd0, 8'd0, 8'd0);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            chk("indep", 32'(grant_o), {30'b0, 1'b1, ind_pat[i % 3]});
        end

        // zero lengths: on=0 -> never, off=0 -> always
        load(MODE_BURST, 9'd0, 8'd0, 8'd3, MODE_BURST, 9'd0, 8'd4, 8'd0);
        run_count(30, c0, c1);
        chk("burst_on0_cnt", c0, 0);
        chk("burst_off0_cnt", c1, 30);

        // both zero -> never; 1/1 -> alternating
        load(MODE_BURST, 9'd0, 8'd0, 8'd0, MODE_BURST, 9'd0, 8'd1, 8'd1);
        run_count(30, c0, c1);
        chk("burst_both0_cnt", c0, 0);
        chk("burst_1_1_cnt", c1, 15);

        // random extremes
        load(MODE_RAND, 9'd0, 8'd0, 8'd0, MODE_RAND, 9'd256, 8'd0, 8'd0);
        run_count(10000, c0, c1);
        chk("rand_bw0_cnt", c0, 0);
        chk("rand_bw256_cnt", c1, 10000);

        // random half and near-full
        load(MODE_RAND, 9'd128, 8'd0, 8'd0, MODE_RAND, 9'd255, 8'd0, 8'd0);
        run_count(10000, c0, c1);
        chk("rand_bw128_in_range", 32'(c0 >= 4700 && c0 <= 5300), 32'd1);
        chk("rand_bw255_in_range", 32'(c1 >= 9900 && c1 <= 9999), 32'd1);

        // reset during BURST_ON with a config load in the same cycle
        load(MODE_BURST, 9'd0, 8'd5, 8'd5, MODE_OFF, 9'd0, 8'd0, 8'd0);
        @(negedge clk);
        chk("burst_pre_rst", 32'(grant_o), 32'h1);
        rst         = 1'b1;
        cfg_valid_i = 1'b1;
        mode_i      = {MODE_ON, MODE_ON};
        @(negedge clk);
        chk("rst_over_cfg", 32'(grant_o), 32'h0);
        rst         = 1'b0;
        cfg_valid_i = 1'b0;
        run_count(20, c0, c1);
        chk("post_rst_ch0_cnt", c0, 0);
        chk("post_rst_ch1_cnt", c1, 0);

`ifdef FIFO_GRANT_STATS_EN
        load(MODE_ON, 9'd0, 8'd0, 8'd0, MODE_OFF, 9'd0, 8'd0, 8'd0);
        run_count(50, c0, c1);
        chk("stat_on50", grant_cnt_o[0], 32'd50);
        chk("stat_off", grant_cnt_o[1], 32'd0);
        load(MODE_ON, 9'd0, 8'd0, 8'd0, MODE_OFF, 9'd0, 8'd0, 8'd0);
        chk("stat_cleared", grant_cnt_o[0], 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/fifo_grant_pattern_gen.md
FIFO_GRANT_PATTERN_GEN -- requirements
Module: fifo_grant_pattern_gen

Interface
REQ-001 SHALL have parameter NUM_CH, default 1: number of independent grant channels (1..16).
REQ-002 SHALL have parameter BW_W, default 8: bandwidth resolution bits.
REQ-003 SHALL have parameter CNT_W, default 8: burst length counter width.
REQ-004 SHALL have parameter SEED, default 16'hACE1: base LFSR seed.
REQ-005 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-006 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-007 SHALL have port cfg_valid_i, input, 1: latch all configuration inputs this cycle.
REQ-008 SHALL have port mode_i, input, NUM_CH x grant_mode_e: per-channel mode.
REQ-009 SHALL have port bw_i, input, NUM_CH x (BW_W+1): per-channel grant probability numerator over 2^BW_W.
REQ-010 SHALL have port burst_on_i, input, NUM_CH x CNT_W: burst ON length in cycles.
REQ-011 SHALL have port burst_off_i, input, NUM_CH x CNT_W: burst OFF length in cycles.
REQ-012 SHALL have port grant_o, output, NUM_CH: registered grant per channel (drives fifo_if grant_in).

Function
REQ-013 SHALL hold per-channel config registers (mode, bw, on_len, off_len), loaded from inputs on a clk edge with cfg_valid_i=1.
REQ-014 SHALL update grant_o one cycle after the config load edge; config applied at edge k, first new grant_o value at edge k+1.
REQ-015 MODE_OFF: grant_o=0 every cycle.
REQ-016 MODE_ON: grant_o=1 every cycle.
REQ-017 MODE_RAND: grant_o = (lfsr[BW_W-1:0] < bw) each cycle; bw=0 -> never, bw>=2^BW_W -> always.
REQ-018 Per-channel 16-bit Galois LFSR, taps 16'hB400, advances every cycle in every mode; seed = SEED ^ channel index, forced to 16'h0001 if zero.
REQ-019 MODE_BURST: per-channel FSM with states IDLE, BURST_ON, BURST_OFF plus CNT_W-bit down-counter.
REQ-020 On entering MODE_BURST (config load): IDLE -> BURST_ON with counter=on_len; grant_o=1 while BURST_ON.
REQ-021 BURST_ON with counter==1 -> BURST_OFF, counter=off_len; BURST_OFF with counter==1 -> BURST_ON, counter=on_len; grant_o=0 while BURST_OFF.
REQ-022 on_len=0 -> channel stays BURST_OFF, grant_o=0; off_len=0 -> stays BURST_ON, grant_o=1; both 0 -> grant_o=0.
REQ-023 Any config load restarts the channel FSM from IDLE (re-entering BURST_ON if mode is BURST); non-BURST modes keep FSM in IDLE.
REQ-024 Channels SHALL be fully independent; no cross-channel interaction.

Reset
REQ-025 rst=1 at an edge: grant_o=0, mode=MODE_OFF, bw=0, lens=0, FSM=IDLE, counters=0, LFSRs=seed; overrides cfg_valid_i in the same cycle.
REQ-026 Reset mid-burst SHALL abort the burst; the first grant after release follows a new config load only.

Configuration
REQ-027 Macro FIFO_GRANT_STATS_EN defined: adds output grant_cnt_o, NUM_CH x 32: per-channel count of cycles with grant_o=1, cleared on rst and on config load, saturating at 32'hFFFF_FFFF.
REQ-028 Macro undefined: port and counters absent; remaining behaviour identical.

Structure
REQ-029 fifo_tb_pkg SHALL hold enum grant_mode_e {MODE_OFF, MODE_RAND, MODE_ON, MODE_BURST} (2 bits), burst_state_e {IDLE, BURST_ON, BURST_OFF}, and LFSR taps constant LFSR_TAPS=16'hB400.
REQ-030 Sub-module fifo_grant_chan SHALL implement one channel (config regs, LFSR, FSM); top instantiates NUM_CH copies via generate.

Verification
REQ-031 Reset for 3 cycles, release, no cfg -> grant_o=0 for 100 cycles.
REQ-032 NUM_CH=2, load ch0 MODE_ON, ch1 MODE_OFF at edge k -> grant_o=2'b01 from edge k+1 onward.
REQ-033 MODE_BURST on_len=3 off_len=2 -> grant_o pattern 1,1,1,0,0 repeating from edge k+1.
REQ-034 MODE_RAND bw=128 (BW_W=8), 10000 cycles -> grant count within 5000 +/- 300; bw=0 -> 0; bw=256 -> 10000.
REQ-035 rst asserted during BURST_ON with cfg_valid_i=1 same cycle -> grant_o=0 next cycle, mode=MODE_OFF.
REQ-036 FIFO_GRANT_STATS_EN, MODE_ON 50 cycles then reload config -> grant_cnt_o=50 before reload, 0 after.
